// File: rtl/seg_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module  : seg_pipe_adder
// Brief   : Segmented, pipelined unsigned add/subtract with wrap/saturate
//           modes and valid/ready handshaking on both ends.
// Revision: 1.0 - initial release
// ============================================================================
module seg_pipe_adder #(
    parameter int W   = 8,
    parameter int A_W = 4,
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [W-1:0]   b,
    input  logic           carry_in,
    input  logic           sub,
    input  logic           sat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   sum,
    output logic           carry_out
);

    localparam int c_STAGES = W / SEG;

    // Stage k registers segment k; the last stage doubles as the output register.
    logic           r_vld [c_STAGES];
    logic           r_sub [c_STAGES];
    logic           r_sat [c_STAGES];
    logic           r_cy  [c_STAGES];
    logic [W-1:0]   r_b   [c_STAGES];
    logic [W-1:0]   r_x   [c_STAGES];
    logic [W-1:0]   r_s   [c_STAGES];

    logic           w_in_vld [c_STAGES];
    logic           w_in_sub [c_STAGES];
    logic           w_in_sat [c_STAGES];
    logic           w_in_cy  [c_STAGES];
    logic [W-1:0]   w_in_b   [c_STAGES];
    logic [W-1:0]   w_in_x   [c_STAGES];
    logic [W-1:0]   w_in_s   [c_STAGES];

    logic [SEG:0]   w_seg    [c_STAGES];
    logic [W-1:0]   w_s_nxt  [c_STAGES];
    logic           w_cy_nxt [c_STAGES];

    logic           w_adv;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[c_STAGES-1];
    assign sum       = r_s[c_STAGES-1];
    assign carry_out = r_cy[c_STAGES-1];

    // Subtract is folded into the first stage as b + ~a + !borrow.
    always_comb begin
        w_in_vld[0] = in_valid;
        w_in_sub[0] = sub;
        w_in_sat[0] = sat;
        w_in_cy[0]  = carry_in ^ sub;
        w_in_b[0]   = b;
        w_in_x[0]   = sub ? ~W'(a) : W'(a);
        w_in_s[0]   = '0;
        for (int k = 1; k < c_STAGES; k++) begin
            w_in_vld[k] = r_vld[k-1];
            w_in_sub[k] = r_sub[k-1];
            w_in_sat[k] = r_sat[k-1];
            w_in_cy[k]  = r_cy[k-1];
            w_in_b[k]   = r_b[k-1];
            w_in_x[k]   = r_x[k-1];
            w_in_s[k]   = r_s[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < c_STAGES; k++) begin
            w_seg[k]    = {1'b0, w_in_b[k][k*SEG +: SEG]}
                        + {1'b0, w_in_x[k][k*SEG +: SEG]}
                        + {{SEG{1'b0}}, w_in_cy[k]};
            w_s_nxt[k]  = w_in_s[k];
            w_s_nxt[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
            w_cy_nxt[k] = w_seg[k][SEG];
        end
        // Saturation only touches the sum; carry_out keeps the raw carry.
        if (w_in_sat[c_STAGES-1]) begin
            if (!w_in_sub[c_STAGES-1] && w_cy_nxt[c_STAGES-1]) begin
                w_s_nxt[c_STAGES-1] = '1;
            end else if (w_in_sub[c_STAGES-1] && !w_cy_nxt[c_STAGES-1]) begin
                w_s_nxt[c_STAGES-1] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_sub[k] <= 1'b0;
                r_sat[k] <= 1'b0;
                r_cy[k]  <= 1'b0;
                r_b[k]   <= '0;
                r_x[k]   <= '0;
                r_s[k]   <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < c_STAGES; k++) begin
                r_vld[k] <= w_in_vld[k];
                r_sub[k] <= w_in_sub[k];
                r_sat[k] <= w_in_sat[k];
                r_cy[k]  <= w_cy_nxt[k];
                r_b[k]   <= w_in_b[k];
                r_x[k]   <= w_in_x[k];
                r_s[k]   <= w_s_nxt[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_pipe_adder
// Brief   : Scoreboard bench for seg_pipe_adder at default parameters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_pipe_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       sub;
    logic       sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry_out;

    int         n_chk;
    int         n_fail;
    int         waited;
    logic [8:0] q[$];

    seg_pipe_adder #(.W(8), .A_W(4), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference result {carry_out, sum} computed in plain integer arithmetic.
    function automatic logic [8:0] model(input logic [3:0] ia, input logic [7:0] ib,
                                         input logic icin, input logic isub, input logic isat);
        int         r;
        logic       co;
        logic [7:0] s;
        if (!isub) begin
            r  = int'(ib) + int'(ia) + int'(icin);
            co = (r > 255);
        end else begin
            r  = int'(ib) - int'(ia) - int'(icin);
            co = (r >= 0);
        end
        s = r[7:0];
        if (isat && !isub && co)  s = 8'hFF;
        if (isat && isub  && !co) s = 8'h00;
        return {co, s};
    endfunction

    // Mid-cycle monitor: handshake values here are the ones the next edge sees.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("result", 32'({carry_out, sum}), 32'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
        if (rst_n && in_valid && in_ready)
            q.push_back(model(a, b, carry_in, sub, sat));
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] ia, input logic [7:0] ib, input logic icin,
                        input logic isub, input logic isat, output int nwait);
        a = ia; b = ib; carry_in = icin; sub = isub; sat = isat; in_valid = 1'b1;
        nwait = 0;
        @(negedge clk);
        while (!in_ready && nwait < 50) begin
            nwait++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; sat = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_carry",     32'(carry_out), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: result visible after the edge following acceptance.
        send(4'h1, 8'h03, 1'b0, 1'b0, 1'b0, waited);
        @(negedge clk);
        check("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("basic_sum", 32'({carry_out, sum}), 32'h004);

        // Directed corner vectors.
        send(4'h1, 8'h0F, 1'b0, 1'b0, 1'b0, waited);
        send(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, waited);
        send(4'hF, 8'hFF, 1'b1, 1'b0, 1'b1, waited);
        send(4'h2, 8'h05, 1'b0, 1'b1, 1'b0, waited);
        send(4'h5, 8'h02, 1'b0, 1'b1, 1'b0, waited);
        send(4'h5, 8'h02, 1'b0, 1'b1, 1'b1, waited);
        send(4'h2, 8'h05, 1'b1, 1'b1, 1'b0, waited);
        check("model_ovf_wrap", 32'(model(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0)), 32'h10F);
        check("model_sub_sat",  32'(model(4'h5, 8'h02, 1'b0, 1'b1, 1'b1)), 32'h000);
        repeat (4) @(posedge clk);
        #1;

        // Streaming with a 3-cycle back-pressure window.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(4'(i), 8'(16 * i), 1'b0, 1'b0, 1'b0, waited);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Full-rate stream with per-operation mode changes.
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(15)), 8'($urandom_range(255)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), waited);
            check("simul_no_wait", 32'(waited), 32'd0);
        end
        repeat (4) @(posedge clk);
        #1;

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(4'h3, 8'h40, 1'b0, 1'b0, 1'b0, waited);
        send(4'h7, 8'h80, 1'b1, 1'b0, 1'b0, waited);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",       32'(sum),       32'd0);
        check("midrst_carry",     32'(carry_out), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        send(4'hA, 8'hF0, 1'b0, 1'b0, 1'b1, waited);
        begin
            int budget;
            budget = 0;
            while (q.size() != 0 && budget < 100) begin
                @(posedge clk);
                budget++;
            end
        end
        check("drain", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
